// File: rtl/led_pkg.sv
// Shared constants and types for the multiplexed LED display blocks.
package led_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [3:0] BCD_BLANK = 4'd15;

  // Active-high segment patterns, bit0 = a ... bit6 = g
  localparam logic [6:0] SEG_PAT_0     = 7'h3F;
  localparam logic [6:0] SEG_PAT_1     = 7'h06;
  localparam logic [6:0] SEG_PAT_2     = 7'h5B;
  localparam logic [6:0] SEG_PAT_3     = 7'h4F;
  localparam logic [6:0] SEG_PAT_4     = 7'h66;
  localparam logic [6:0] SEG_PAT_5     = 7'h6D;
  localparam logic [6:0] SEG_PAT_6     = 7'h7D;
  localparam logic [6:0] SEG_PAT_7     = 7'h07;
  localparam logic [6:0] SEG_PAT_8     = 7'h7F;
  localparam logic [6:0] SEG_PAT_9     = 7'h6F;
  localparam logic [6:0] SEG_PAT_DASH  = 7'h40;
  localparam logic [6:0] SEG_PAT_BLANK = 7'h00;

  typedef logic [3:0] digit_t;
  typedef digit_t digit_arr_t [0:NUM_DIGITS-1];

  function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [1:0] idx);
    digit_onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Digit data and display pin bundle between a digit source (master) and the scan driver (slave).
interface seg7_scan_driver_if;
  import led_pkg::*;

  digit_arr_t              bcd_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    en;
  logic [6:0]              seg_out;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   an_out;

  modport master (
    output bcd_in, dp_in, en,
    input  seg_out, dp_out, an_out
  );

  modport slave (
    input  bcd_in, dp_in, en,
    output seg_out, dp_out, an_out
  );

endinterface

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-high 7-segment decoder; 10..14 show a dash, 15 is blank.
module seg7_decoder
  import led_pkg::*;
(
  input  digit_t     bcd,
  output logic [6:0] seg
);

  // Pattern lookup
  always_comb begin
    seg = SEG_PAT_BLANK;
    case (bcd)
      4'd0:    seg = SEG_PAT_0;
      4'd1:    seg = SEG_PAT_1;
      4'd2:    seg = SEG_PAT_2;
      4'd3:    seg = SEG_PAT_3;
      4'd4:    seg = SEG_PAT_4;
      4'd5:    seg = SEG_PAT_5;
      4'd6:    seg = SEG_PAT_6;
      4'd7:    seg = SEG_PAT_7;
      4'd8:    seg = SEG_PAT_8;
      4'd9:    seg = SEG_PAT_9;
      4'd10, 4'd11, 4'd12, 4'd13, 4'd14:
               seg = SEG_PAT_DASH;
      default: seg = SEG_PAT_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit 7-segment scan driver with per-frame shadow latching
// and a blanking interval at the start of every digit slot.
module seg7_scan_driver
  import led_pkg::*;
#(
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS     = 1000,
  parameter bit SEG_ACTIVE_LOW  = 1'b1,
  parameter bit AN_ACTIVE_LOW   = 1'b1
)(
  input  logic              clk,
  input  logic              rst_n,
  seg7_scan_driver_if.slave bus
);

  localparam int TICK_W = (TICKS_PER_DIGIT > 2) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam logic [TICK_W-1:0] TICK_ZERO = {TICK_W{1'b0}};
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_DIGIT - 1);
  localparam logic [TICK_W-1:0] BLANK_END = TICK_W'(BLANK_TICKS);

  localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? 4'hF : 4'h0;

  if (TICKS_PER_DIGIT < 2 || BLANK_TICKS < 0 || BLANK_TICKS >= TICKS_PER_DIGIT) begin : g_param_check
    $error("seg7_scan_driver: requires TICKS_PER_DIGIT >= 2 and 0 <= BLANK_TICKS < TICKS_PER_DIGIT");
  end

  logic [TICK_W-1:0]     tick_cnt_r;
  logic [1:0]            idx_r;
  digit_arr_t            shadow_bcd_r;
  logic [NUM_DIGITS-1:0] shadow_dp_r;
  logic [6:0]            seg_r;
  logic                  dp_r;
  logic [NUM_DIGITS-1:0] an_r;

  logic                  frame_start_s;
  logic                  tick_wrap_s;
  digit_t                digit_sel_s;
  logic                  dp_sel_s;
  logic [6:0]            pat_s;
  logic [6:0]            seg_nxt_s;
  logic                  dp_nxt_s;
  logic [NUM_DIGITS-1:0] an_act_s;
  logic [NUM_DIGITS-1:0] an_nxt_s;

  // Slot timing and digit selection; the frame-start cycle bypasses the shadow
  // so slot 0 shows the freshly latched digit from its very first tick.
  always_comb begin
    frame_start_s = (tick_cnt_r == TICK_ZERO) && (idx_r == 2'd0);
    tick_wrap_s   = (tick_cnt_r == TICK_LAST);
    if (frame_start_s) begin
      digit_sel_s = bus.bcd_in[idx_r];
      dp_sel_s    = bus.dp_in[idx_r];
    end else begin
      digit_sel_s = shadow_bcd_r[idx_r];
      dp_sel_s    = shadow_dp_r[idx_r];
    end
  end

  seg7_decoder u_decoder (
    .bcd (digit_sel_s),
    .seg (pat_s)
  );

  // Pin polarity and anode gating (blank interval and display enable)
  always_comb begin
    if (SEG_ACTIVE_LOW) begin
      seg_nxt_s = ~pat_s;
      dp_nxt_s  = ~dp_sel_s;
    end else begin
      seg_nxt_s = pat_s;
      dp_nxt_s  = dp_sel_s;
    end
    if (bus.en && (tick_cnt_r >= BLANK_END)) begin
      an_act_s = digit_onehot(idx_r);
    end else begin
      an_act_s = 4'b0000;
    end
    if (AN_ACTIVE_LOW) begin
      an_nxt_s = ~an_act_s;
    end else begin
      an_nxt_s = an_act_s;
    end
  end

  // Tick counter and digit index; keep running regardless of en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_r <= TICK_ZERO;
      idx_r      <= 2'd0;
    end else if (tick_wrap_s) begin
      tick_cnt_r <= TICK_ZERO;
      idx_r      <= idx_r + 2'd1;
    end else begin
      tick_cnt_r <= tick_cnt_r + TICK_ONE;
    end
  end

  // Shadow registers, loaded once per frame so a frame never tears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_bcd_r[i] <= BCD_BLANK;
      end
      shadow_dp_r <= 4'b0000;
    end else if (frame_start_s) begin
      shadow_bcd_r <= bus.bcd_in;
      shadow_dp_r  <= bus.dp_in;
    end
  end

  // Registered display pins, one cycle behind tick_cnt/idx
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r <= SEG_OFF;
      dp_r  <= DP_OFF;
      an_r  <= AN_OFF;
    end else begin
      seg_r <= seg_nxt_s;
      dp_r  <= dp_nxt_s;
      an_r  <= an_nxt_s;
    end
  end

  assign bus.seg_out = seg_r;
  assign bus.dp_out  = dp_r;
  assign bus.an_out  = an_r;

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter TICKS_PER_DIGIT, default 100000, clock cycles per digit slot.
REQ-002 SHALL have parameter BLANK_TICKS, default 1000, anode-off cycles at the start of each slot (anti-ghosting).
REQ-003 SHALL have parameter SEG_ACTIVE_LOW, default 1, meaning segment and decimal-point pins are active low.
REQ-004 SHALL have parameter AN_ACTIVE_LOW, default 1, meaning anode pins are active low.
REQ-005 clk  input  1  system clock; one clock domain, all logic on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 bcd_in  input  4 x 4 (unpacked [0:3])  digit values; index 0 = least significant; value 15 = blank.
REQ-008 dp_in  input  4  decimal-point request per digit, same indexing.
REQ-009 en  input  1  display enable; low forces all anodes inactive.
REQ-010 seg_out  output  7  segments, bit0 = a … bit6 = g.
REQ-011 dp_out  output  1  decimal point of the currently driven digit.
REQ-012 an_out  output  4  anode select, bit i = digit i.

Function
REQ-013 tick_cnt SHALL count 0..TICKS_PER_DIGIT-1 and wrap to 0; on wrap, digit index idx SHALL advance 0→1→2→3→0.
REQ-014 When tick_cnt==0 and idx==0, the block SHALL latch bcd_in and dp_in into shadow registers; the shadow registers SHALL NOT change at any other time (no tearing within a frame).
REQ-015 During tick_cnt < BLANK_TICKS, all anodes SHALL be inactive; during tick_cnt >= BLANK_TICKS, only anode idx SHALL be active, provided en is high.
REQ-016 seg_out SHALL carry the pattern of shadow digit idx for the whole slot; dp_out SHALL carry shadow dp[idx].
REQ-017 Patterns, active-high {g..a}: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, 10..14=40 (dash, error), 15=00 (blank); output inverted when SEG_ACTIVE_LOW=1.
REQ-018 A blank digit (15) SHALL still receive its anode slot, with all segments off and dp_out per shadow dp.
REQ-019 seg_out, dp_out and an_out SHALL be registered, lagging tick_cnt/idx by exactly one cycle.
REQ-020 en low SHALL force an_out inactive from the next clock edge; tick_cnt, idx and frame latching SHALL keep running, and en high SHALL resume the scan at its current position.
REQ-021 TICKS_PER_DIGIT >= 2 and BLANK_TICKS < TICKS_PER_DIGIT SHALL be enforced by an elaboration-time check.

Reset
REQ-022 While rst_n is low: tick_cnt=0, idx=0, shadow digits=15, shadow dp=0, seg_out and dp_out inactive (all 1s when active-low), an_out inactive (4'b1111 when active-low).
REQ-023 Reset asserted mid-slot SHALL take effect immediately, without waiting for a clock edge; the first cycle after release SHALL latch a new frame (per REQ-014).

Structure
REQ-024 Shared package led_pkg SHALL hold NUM_DIGITS=4, BCD_BLANK=4'd15, the segment pattern constants and the digit-array typedef.
REQ-025 Decoding SHALL live in a combinational sub-module seg7_decoder (4-bit in, 7-bit active-high out); the polarity inversion SHALL be applied in seg7_scan_driver.

Verification (TICKS_PER_DIGIT=8, BLANK_TICKS=2, active-low)
REQ-026 Reset held -> an_out=4'b1111, seg_out=7'h7F, dp_out=1.
REQ-027 bcd_in={4,3,2,1} (idx0=4), en=1 -> across 32 cycles: an_out 1110,1101,1011,0111, each active 6 cycles after 2 off; seg_out=~66,~4F,~5B,~06.
REQ-028 bcd_in idx3=15, idx2=15 (value 42) -> anodes 2 and 3 still pulse; seg_out=7'h7F during their slots.
REQ-029 bcd_in changed at idx=1 mid-frame -> old value displayed until the next idx0 tick0, new value thereafter.
REQ-030 en dropped during idx=2 drive -> an_out=1111 one cycle later; en raised -> scan resumes at the live idx/tick.
REQ-031 rst_n pulsed mid-slot on idx=3 -> outputs inactive immediately; after release the scan restarts at idx0 with a fresh latch; dp_in=4'b0100 -> dp_out=0 only in the idx2 slot.
